// File: rtl/z180_mem_ctl.sv
// z180_mem_ctl: memory-cycle controller between the Z8S180 bus and board SRAM.
//
// The CPU strobes are synchronised to hwclk. This block then generates the SRAM
// ce_n/oe_n/we_n strobes and holds wait_n low for WAIT_CYCLES clocks. A boot-ROM
// overlay maps the internal ROM over the bottom of memory for reads. The overlay
// stays on until software writes to I/O port BOOT_PORT.
//
// Ports:
//   hwclk     system clock
//   reset     synchronous, active-high reset
//   a         CPU address bus (20 bits)
//   mreq_n    CPU memory request (async)
//   iorq_n    CPU I/O request (async)
//   rd_n      CPU read strobe (async)
//   wr_n      CPU write strobe (async)
//   m1_n      CPU opcode fetch / int-ack qualifier (async)
//   rfsh_n    CPU refresh indicator (async)
//   ce_n      SRAM chip enable, active low
//   oe_n      SRAM output enable, active low
//   we_n      SRAM write enable, active low
//   wait_n    CPU wait request, active low
//   rom_oe    high: top level drives d from boot ROM
//   rom_addr  boot ROM address, latched at cycle start
//   boot_en   boot-ROM overlay active
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | no cycle in progress, watching synced strobes
// MEM_WAIT   | memory cycle started, wait_n low, counting wait states
// MEM_ACTIVE | memory strobes held until synced mreq_n returns high
// IO_ACTIVE  | I/O write seen, waiting for synced iorq_n to return high

module z180_mem_ctl #(
    parameter int         WAIT_CYCLES   = 2,
    parameter int         ROM_ADDR_BITS = 12,
    parameter logic [7:0] BOOT_PORT     = 8'h00
) (
    input  logic                     hwclk,
    input  logic                     reset,
    input  logic [19:0]              a,
    input  logic                     mreq_n,
    input  logic                     iorq_n,
    input  logic                     rd_n,
    input  logic                     wr_n,
    input  logic                     m1_n,
    input  logic                     rfsh_n,
    output logic                     ce_n,
    output logic                     oe_n,
    output logic                     we_n,
    output logic                     wait_n,
    output logic                     rom_oe,
    output logic [ROM_ADDR_BITS-1:0] rom_addr,
    output logic                     boot_en
);

    localparam int CW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MEM_WAIT   = 2'd1,
        MEM_ACTIVE = 2'd2,
        IO_ACTIVE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Two-flop synchronisers, packed as {rfsh, m1, wr, rd, iorq, mreq}.
    logic [5:0] sync1_q, sync2_q;
    logic       mreq_s, iorq_s, rd_s, wr_s, m1_s, rfsh_s;

    always_ff @(posedge hwclk) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {rfsh_n, m1_n, wr_n, rd_n, iorq_n, mreq_n};
            sync2_q <= sync1_q;
        end
    end

    assign {rfsh_s, m1_s, wr_s, rd_s, iorq_s, mreq_s} = sync2_q;

    logic [CW-1:0]            count_q, count_d;
    logic                     ce_n_d, oe_n_d, we_n_d, wait_n_d, rom_oe_d, boot_en_d;
    logic [ROM_ADDR_BITS-1:0] rom_addr_d;
    logic                     mem_start, io_start, rom_hit;

    // Refresh cycles assert mreq_n but must not touch the SRAM.
    assign mem_start = !mreq_s && rfsh_s && (!rd_s || !wr_s);
    // An int-ack asserts iorq_n with m1_n low, so m1_n high marks a real I/O write.
    assign io_start  = !iorq_s && !wr_s && m1_s;
    // Only reads are redirected to the ROM. Writes to the overlay region shadow into SRAM.
    assign rom_hit   = boot_en && !rd_s && (a[19:ROM_ADDR_BITS] == '0);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ce_n_d     = ce_n;
        oe_n_d     = oe_n;
        we_n_d     = we_n;
        wait_n_d   = wait_n;
        rom_oe_d   = rom_oe;
        rom_addr_d = rom_addr;
        boot_en_d  = boot_en;

        case (state_q)
            IDLE: begin
                if (mem_start) begin
                    rom_addr_d = a[ROM_ADDR_BITS-1:0];
                    if (rom_hit) begin
                        rom_oe_d = 1'b1;
                    end else begin
                        ce_n_d = 1'b0;
                        // When rd and wr are both low, the cycle is treated as a read.
                        if (!rd_s) oe_n_d = 1'b0;
                        else       we_n_d = 1'b0;
                    end
                    if (WAIT_CYCLES > 0) begin
                        state_d  = MEM_WAIT;
                        count_d  = WAIT_LOAD[CW-1:0];
                        wait_n_d = 1'b0;
                    end else begin
                        state_d = MEM_ACTIVE;
                    end
                end else if (io_start) begin
                    state_d = IO_ACTIVE;
                    if (a[7:0] == BOOT_PORT) boot_en_d = 1'b0;
                end
            end

            MEM_WAIT: begin
                if (count_q == '0) begin
                    state_d  = MEM_ACTIVE;
                    wait_n_d = 1'b1;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end

            MEM_ACTIVE: begin
                if (mreq_s) begin
                    state_d  = IDLE;
                    ce_n_d   = 1'b1;
                    oe_n_d   = 1'b1;
                    we_n_d   = 1'b1;
                    rom_oe_d = 1'b0;
                end
            end

            IO_ACTIVE: begin
                if (iorq_s) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            ce_n     <= 1'b1;
            oe_n     <= 1'b1;
            we_n     <= 1'b1;
            wait_n   <= 1'b1;
            rom_oe   <= 1'b0;
            rom_addr <= '0;
            boot_en  <= 1'b1;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ce_n     <= ce_n_d;
            oe_n     <= oe_n_d;
            we_n     <= we_n_d;
            wait_n   <= wait_n_d;
            rom_oe   <= rom_oe_d;
            rom_addr <= rom_addr_d;
            boot_en  <= boot_en_d;
        end
    end

endmodule

// File: tb/tb_z180_mem_ctl.sv
module tb_z180_mem_ctl;

    logic        hwclk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] a = '0;
    logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic        m1_n = 1'b1, rfsh_n = 1'b1;

    logic        ce_n, oe_n, we_n, wait_n, rom_oe, boot_en;
    logic [11:0] rom_addr;
    logic        ce_n0, oe_n0, we_n0, wait_n0, rom_oe0, boot_en0;
    logic [11:0] rom_addr0;

    int n_vec = 0;
    int n_err = 0;

    always #5 hwclk = ~hwclk;

    z180_mem_ctl dut (
        .hwclk(hwclk), .reset(reset), .a(a),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .m1_n(m1_n), .rfsh_n(rfsh_n),
        .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n), .wait_n(wait_n),
        .rom_oe(rom_oe), .rom_addr(rom_addr), .boot_en(boot_en)
    );

    // No-wait-state build, driven by the same bus.
    z180_mem_ctl #(.WAIT_CYCLES(0)) dut0 (
        .hwclk(hwclk), .reset(reset), .a(a),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .m1_n(m1_n), .rfsh_n(rfsh_n),
        .ce_n(ce_n0), .oe_n(oe_n0), .we_n(we_n0), .wait_n(wait_n0),
        .rom_oe(rom_oe0), .rom_addr(rom_addr0), .boot_en(boot_en0)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge hwclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        m1_n = 1'b1; rfsh_n = 1'b1;
    endtask

    initial begin
        // Reset, then idle.
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("rst_ce_n", ce_n, 1);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_we_n", we_n, 1);
        chk("rst_wait_n", wait_n, 1);
        chk("rst_rom_oe", rom_oe, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_boot_en", boot_en, 1);
        tick(5);
        chk("idle_boot_en", boot_en, 1);
        chk("idle_ce_n", ce_n, 1);

        // ROM overlay read at 0x00010 with two wait states.
        a = 20'h00010; mreq_n = 1'b0; rd_n = 1'b0;
        tick(2);
        chk("rom_rd_e2_rom_oe", rom_oe, 0);
        chk("rom_rd_e2_wait_n", wait_n, 1);
        tick(1);
        chk("rom_rd_rom_oe", rom_oe, 1);
        chk("rom_rd_rom_addr", rom_addr, 20'h010);
        chk("rom_rd_ce_n", ce_n, 1);
        chk("rom_rd_oe_n", oe_n, 1);
        chk("rom_rd_wait_n", wait_n, 0);
        chk("ws0_rom_oe", rom_oe0, 1);
        chk("ws0_wait_n", wait_n0, 1);
        tick(1);
        chk("rom_rd_wait_n_e4", wait_n, 0);
        tick(1);
        chk("rom_rd_wait_n_e5", wait_n, 1);
        bus_idle();
        tick(2);
        chk("rom_rd_rel_e2_rom_oe", rom_oe, 1);
        tick(1);
        chk("rom_rd_rel_rom_oe", rom_oe, 0);
        chk("rom_rd_hold_addr", rom_addr, 20'h010);
        tick(2);

        // Write into the overlay region goes to SRAM.
        a = 20'h00010; mreq_n = 1'b0; wr_n = 1'b0;
        tick(3);
        chk("wr_ce_n", ce_n, 0);
        chk("wr_we_n", we_n, 0);
        chk("wr_oe_n", oe_n, 1);
        chk("wr_rom_oe", rom_oe, 0);
        tick(2);
        bus_idle();
        tick(3);
        chk("wr_end_we_n", we_n, 1);
        chk("wr_end_ce_n", ce_n, 1);
        tick(2);

        // Read just above the 4 KiB overlay.
        a = 20'h01000; mreq_n = 1'b0; rd_n = 1'b0;
        tick(3);
        chk("rd1000_ce_n", ce_n, 0);
        chk("rd1000_oe_n", oe_n, 0);
        chk("rd1000_rom_oe", rom_oe, 0);
        tick(2);
        bus_idle();
        tick(5);

        // rd and wr both low count as a read.
        a = 20'h02000; mreq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
        tick(3);
        chk("rdwr_oe_n", oe_n, 0);
        chk("rdwr_we_n", we_n, 1);
        tick(2);
        bus_idle();
        tick(5);

        // I/O write to port 0x01 leaves the overlay on.
        a = 20'h00001; iorq_n = 1'b0; wr_n = 1'b0;
        tick(3);
        chk("io01_boot_en", boot_en, 1);
        chk("io01_ce_n", ce_n, 1);
        bus_idle();
        tick(5);

        // Int-ack to port 0 (m1_n low) leaves the overlay on.
        a = 20'h00000; iorq_n = 1'b0; m1_n = 1'b0; wr_n = 1'b0;
        tick(4);
        chk("intack_boot_en", boot_en, 1);
        bus_idle();
        tick(5);

        // I/O write to port 0 disables the overlay.
        a = 20'h00000; iorq_n = 1'b0; wr_n = 1'b0;
        tick(2);
        chk("io00_e2_boot_en", boot_en, 1);
        tick(1);
        chk("io00_boot_en", boot_en, 0);
        chk("io00_ce_n", ce_n, 1);
        chk("io00_we_n", we_n, 1);
        chk("io00_rom_oe", rom_oe, 0);
        chk("io00_wait_n", wait_n, 1);
        chk("ws0_io00_boot_en", boot_en0, 0);
        tick(3);
        bus_idle();
        tick(5);
        chk("io00_sticky_boot_en", boot_en, 0);

        // Same read as before now hits SRAM.
        a = 20'h00010; mreq_n = 1'b0; rd_n = 1'b0;
        tick(3);
        chk("rd_post_ce_n", ce_n, 0);
        chk("rd_post_oe_n", oe_n, 0);
        chk("rd_post_rom_oe", rom_oe, 0);
        chk("ws0_rd_post_wait_n", wait_n0, 1);
        chk("ws0_rd_post_ce_n", ce_n0, 0);
        tick(2);
        bus_idle();
        tick(5);

        // Refresh cycle is ignored.
        a = 20'h00200; mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0;
        tick(4);
        chk("rfsh_ce_n", ce_n, 1);
        chk("rfsh_oe_n", oe_n, 1);
        chk("rfsh_wait_n", wait_n, 1);
        chk("rfsh_rom_oe", rom_oe, 0);
        bus_idle();
        tick(5);

        // Reset while wait states are pending.
        a = 20'h00100; mreq_n = 1'b0; rd_n = 1'b0;
        tick(3);
        chk("mw_wait_n", wait_n, 0);
        chk("mw_ce_n", ce_n, 0);
        reset = 1'b1;
        tick(1);
        chk("mw_rst_wait_n", wait_n, 1);
        chk("mw_rst_ce_n", ce_n, 1);
        chk("mw_rst_oe_n", oe_n, 1);
        chk("mw_rst_boot_en", boot_en, 1);
        chk("mw_rst_rom_addr", rom_addr, 0);
        reset = 1'b0;
        bus_idle();
        tick(4);

        // Fresh read after reset uses the overlay again.
        a = 20'h00020; mreq_n = 1'b0; rd_n = 1'b0;
        tick(3);
        chk("post_rst_rom_oe", rom_oe, 1);
        chk("post_rst_rom_addr", rom_addr, 20'h020);
        chk("post_rst_wait_n", wait_n, 0);
        tick(2);
        chk("post_rst_wait_end", wait_n, 1);
        bus_idle();
        tick(3);
        chk("post_rst_rom_oe_end", rom_oe, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
